// File: rtl/riscv_trace_buffer.sv
// rtl/riscv_trace_buffer.sv - retirement trace capture buffer with FWFT drain port
// Optional feature macro: TRACE_TIMESTAMP_EN (per-entry cycle timestamp on rd_time)
module riscv_trace_buffer #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 16,
  parameter int DROP_W = 8,
  parameter int TS_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cap_valid,
  input  logic [XLEN-1:0]            cap_pc,
  input  logic [XLEN-1:0]            cap_instr,
  input  logic [XLEN-1:0]            cap_result,
  input  logic                       cfg_wrap,
  input  logic                       clear,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [XLEN-1:0]            rd_pc,
  output logic [XLEN-1:0]            rd_instr,
  output logic [XLEN-1:0]            rd_result,
  output logic [TS_W-1:0]            rd_time,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [DROP_W-1:0]          dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [XLEN-1:0] mem_pc     [DEPTH];
  logic [XLEN-1:0] mem_instr  [DEPTH];
  logic [XLEN-1:0] mem_result [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          pop;
  logic          do_write;

  assign full     = (count == FULL_CNT);
  assign rd_valid = (count != '0);
  // A pop is only honoured when there is something to pop.
  assign pop      = rd_valid & rd_ready;
  // Full and no room being made: only write when allowed to overwrite the oldest.
  assign do_write = cap_valid & ~clear & (~full | pop | cfg_wrap);

  assign rd_pc     = mem_pc[rd_ptr];
  assign rd_instr  = mem_instr[rd_ptr];
  assign rd_result = mem_result[rd_ptr];

  // Entry storage: written at wr_ptr, never reset; gated off while reset is high.
  always_ff @(posedge clk) begin
    if (do_write && !reset) begin
      mem_pc[wr_ptr]     <= cap_pc;
      mem_instr[wr_ptr]  <= cap_instr;
      mem_result[wr_ptr] <= cap_result;
    end
  end

  // Pointer, occupancy and loss bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      dropped  <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      dropped  <= '0;
    end else if (cap_valid) begin
      if (!full) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        else     count  <= count + 1'b1;
      end else if (pop || cfg_wrap) begin
        // Full: the new entry replaces the head, so both pointers move together.
        wr_ptr <= wr_ptr + 1'b1;
        rd_ptr <= rd_ptr + 1'b1;
        if (!pop) begin
          overflow <= 1'b1;
          if (dropped != '1) dropped <= dropped + 1'b1;
        end
      end else begin
        overflow <= 1'b1;
        if (dropped != '1) dropped <= dropped + 1'b1;
      end
    end else if (pop) begin
      rd_ptr <= rd_ptr + 1'b1;
      count  <= count - 1'b1;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts;
  logic [TS_W-1:0] mem_time [DEPTH];

  // Free-running cycle counter; clear deliberately leaves it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ts <= '0;
    else       ts <= ts + 1'b1;
  end

  // Timestamp storage alongside each entry.
  always_ff @(posedge clk) begin
    if (do_write && !reset) mem_time[wr_ptr] <= ts;
  end

  assign rd_time = mem_time[rd_ptr];
`else
  assign rd_time = '0;
`endif

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// tb/tb_riscv_trace_buffer.sv - directed self-checking bench for riscv_trace_buffer
module tb_riscv_trace_buffer;

  logic        clk;
  logic        reset;
  logic        cap_valid;
  logic [31:0] cap_pc;
  logic [31:0] cap_instr;
  logic [31:0] cap_result;
  logic        cfg_wrap;
  logic        clear;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_pc;
  logic [31:0] rd_instr;
  logic [31:0] rd_result;
  logic [15:0] rd_time;
  logic [4:0]  count;
  logic        overflow;
  logic [7:0]  dropped;

  int n_assert = 0;
  int n_fail   = 0;

  riscv_trace_buffer #(.XLEN(32), .DEPTH(16), .DROP_W(8), .TS_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .cap_valid  (cap_valid),
    .cap_pc     (cap_pc),
    .cap_instr  (cap_instr),
    .cap_result (cap_result),
    .cfg_wrap   (cfg_wrap),
    .clear      (clear),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_pc      (rd_pc),
    .rd_instr   (rd_instr),
    .rd_result  (rd_result),
    .rd_time    (rd_time),
    .count      (count),
    .overflow   (overflow),
    .dropped    (dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc);
    cap_valid  = 1'b1;
    cap_pc     = pc;
    cap_instr  = pc ^ 32'h0000_0013;
    cap_result = pc + 32'd1;
    step();
    cap_valid  = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    logic [15:0] ts_exp;
    reset = 1'b1; cap_valid = 1'b0; cap_pc = '0; cap_instr = '0; cap_result = '0;
    cfg_wrap = 1'b0; clear = 1'b0; rd_ready = 1'b0;
    step(); step();
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_valid", 32'(rd_valid), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_dropped", 32'(dropped), 32'd0);
    reset = 1'b0;

    // Ten idle edges, then three back-to-back pushes sample timestamps 10,11,12.
    repeat (10) step();
    push(32'h0); push(32'h4); push(32'h8);
    chk("three_count", 32'(count), 32'd3);
    chk("three_valid", 32'(rd_valid), 32'd1);
    chk("three_head_pc", rd_pc, 32'h0);
    chk("three_head_instr", rd_instr, 32'h13);
    chk("three_head_result", rd_result, 32'h1);
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
`ifdef TRACE_TIMESTAMP_EN
      ts_exp = 16'(10 + i);
`else
      ts_exp = 16'd0;
`endif
      chk("drain3_pc", rd_pc, 32'(4 * i));
      chk("drain3_time", 32'(rd_time), 32'(ts_exp));
      step();
    end
    rd_ready = 1'b0;
    chk("drain3_valid", 32'(rd_valid), 32'd0);
    chk("drain3_count", 32'(count), 32'd0);

    // Drop-newest on overflow.
    cfg_wrap = 1'b0;
    for (int i = 0; i < 20; i++) push(32'(4 * i));
    chk("nowrap_count", 32'(count), 32'd16);
    chk("nowrap_overflow", 32'(overflow), 32'd1);
    chk("nowrap_dropped", 32'(dropped), 32'd4);
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("nowrap_drain_pc", rd_pc, 32'(4 * i));
      step();
    end
    rd_ready = 1'b0;
    chk("nowrap_empty", 32'(rd_valid), 32'd0);

    // Overwrite-oldest on overflow.
    do_clear();
    chk("clear_overflow", 32'(overflow), 32'd0);
    chk("clear_dropped", 32'(dropped), 32'd0);
    cfg_wrap = 1'b1;
    for (int i = 0; i < 20; i++) push(32'(4 * i));
    chk("wrap_count", 32'(count), 32'd16);
    chk("wrap_overflow", 32'(overflow), 32'd1);
    chk("wrap_dropped", 32'(dropped), 32'd4);
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("wrap_drain_pc", rd_pc, 32'(32'h10 + 4 * i));
      step();
    end
    rd_ready = 1'b0;
    chk("wrap_empty_count", 32'(count), 32'd0);

    // Full buffer, push and pop on the same edge.
    do_clear();
    cfg_wrap = 1'b0;
    for (int i = 0; i < 16; i++) push(32'(4 * i));
    rd_ready = 1'b1;
    push(32'h100);
    rd_ready = 1'b0;
    chk("fullpp_count", 32'(count), 32'd16);
    chk("fullpp_overflow", 32'(overflow), 32'd0);
    chk("fullpp_head_pc", rd_pc, 32'h4);

    // Empty buffer, push and pop on the same edge.
    do_clear();
    rd_ready = 1'b1;
    push(32'h200);
    rd_ready = 1'b0;
    chk("emptypp_count", 32'(count), 32'd1);
    chk("emptypp_valid", 32'(rd_valid), 32'd1);
    chk("emptypp_head_pc", rd_pc, 32'h200);

    // Clear wins over a simultaneous push.
    do_clear();
    for (int i = 0; i < 5; i++) push(32'(32'h300 + 4 * i));
    chk("pre_clear_count", 32'(count), 32'd5);
    clear = 1'b1; cap_valid = 1'b1; cap_pc = 32'h400;
    step();
    clear = 1'b0; cap_valid = 1'b0;
    chk("clearpush_count", 32'(count), 32'd0);
    chk("clearpush_valid", 32'(rd_valid), 32'd0);
    chk("clearpush_overflow", 32'(overflow), 32'd0);

    // Asynchronous reset mid-cycle.
    for (int i = 0; i < 5; i++) push(32'(32'h500 + 4 * i));
    chk("pre_areset_count", 32'(count), 32'd5);
    #2;
    reset = 1'b1;
    #1;
    chk("areset_count", 32'(count), 32'd0);
    chk("areset_valid", 32'(rd_valid), 32'd0);
    step();
    reset = 1'b0;

    // Saturation of the dropped counter.
    cfg_wrap = 1'b0;
    for (int i = 0; i < 316; i++) push(32'(i));
    chk("sat_dropped", 32'(dropped), 32'd255);
    chk("sat_count", 32'(count), 32'd16);
    chk("sat_head_pc", rd_pc, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
